// File: rtl/nibble_pair_sequencer.sv
// nibble_pair_sequencer
//
// Drives the nibble-adder datapath from its input side and checks what comes
// back on its output side. Consecutive nibbles arriving over a valid/ready
// handshake are paired into one operand byte {A,B} and presented to the adder.
// After a fixed latency, the adder result is captured and compared against a
// locally computed sum. The block reports the result and keeps pair and error
// counters.
//
// Ports:
//   clk         system clock; all logic runs on the rising edge
//   reset       synchronous, active-high reset; overrides everything
//   nib_in      incoming operand nibble
//   nib_valid   nib_in is valid this cycle
//   nib_ready   sequencer accepts nib_in this cycle (registered)
//   pair_out    operand byte to the adder: [7:4]=A (first nibble), [3:0]=B
//   res_in      adder output bus; [3:0] is the sum, [7:4] must read zero
//   res_valid   one-cycle pulse; the result fields below are valid
//   res_data    captured res_in[3:0]; held between pulses
//   res_carry   carry-out of A+B, computed locally; held between pulses
//   mismatch    adder result disagrees with the local sum; held between pulses
//   pair_count  pairs completed; wraps modulo 2^CNT_W
//   err_count   mismatches seen; saturates at 2^CNT_W-1
//   busy        high whenever the sequencer is not waiting for an A nibble

module nibble_pair_sequencer #(
    parameter int RESULT_LATENCY = 1,
    parameter int CNT_W          = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       nib_in,
    input  logic             nib_valid,
    output logic             nib_ready,
    output logic [7:0]       pair_out,
    input  logic [7:0]       res_in,
    output logic             res_valid,
    output logic [3:0]       res_data,
    output logic             res_carry,
    output logic             mismatch,
    output logic [CNT_W-1:0] pair_count,
    output logic [CNT_W-1:0] err_count,
    output logic             busy
);

    typedef enum logic [1:0] {
        ST_GET_A,
        ST_GET_B,
        ST_WAIT,
        ST_REPORT
    } state_t;

    // The wait counter covers latencies 1..15.
    localparam logic [3:0]       LATENCY  = 4'(RESULT_LATENCY);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_FULL = {CNT_W{1'b1}};

    state_t           state_q;
    logic [3:0]       a_q;
    logic [3:0]       b_q;
    logic [3:0]       wait_cnt_q;
    logic             nib_ready_q;
    logic [7:0]       pair_out_q;
    logic             res_valid_q;
    logic [3:0]       res_data_q;
    logic             res_carry_q;
    logic             mismatch_q;
    logic [CNT_W-1:0] pair_count_q;
    logic [CNT_W-1:0] err_count_q;
    logic             busy_q;

    logic             nib_xfer;
    logic [4:0]       sum_d;
    logic             mismatch_d;
    logic [CNT_W-1:0] pair_count_d;
    logic [CNT_W-1:0] err_count_d;

    // A nibble transfers only when both sides agree on the same edge.
    assign nib_xfer = nib_valid && nib_ready_q;

    // The reference sum is zero-extended to five bits so bit 4 is the carry
    // that the adder itself drops. Only the low nibble is compared against
    // the adder. A nonzero upper nibble on the bus is a fault in its own
    // right.
    assign sum_d      = {1'b0, a_q} + {1'b0, b_q};
    assign mismatch_d = (res_in[3:0] != sum_d[3:0]) || (res_in[7:4] != 4'h0);

    // pair_count wraps naturally. err_count must stick once it is all-ones.
    assign pair_count_d = pair_count_q + CNT_ONE;
    assign err_count_d  = (mismatch_d && (err_count_q != CNT_FULL))
                          ? (err_count_q + CNT_ONE) : err_count_q;

    // Sequencer FSM. Every output is a register that is updated here.
    // Result fields and counters are loaded on the edge that enters REPORT,
    // so they are visible during the same cycle in which res_valid is high.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_GET_A;
            a_q          <= 4'h0;
            b_q          <= 4'h0;
            wait_cnt_q   <= 4'h0;
            nib_ready_q  <= 1'b1;
            pair_out_q   <= 8'h00;
            res_valid_q  <= 1'b0;
            res_data_q   <= 4'h0;
            res_carry_q  <= 1'b0;
            mismatch_q   <= 1'b0;
            pair_count_q <= '0;
            err_count_q  <= '0;
            busy_q       <= 1'b0;
        end else begin
            case (state_q)
                ST_GET_A: begin
                    if (nib_xfer) begin
                        a_q     <= nib_in;
                        busy_q  <= 1'b1;
                        state_q <= ST_GET_B;
                    end
                end

                // The sequencer can wait here indefinitely for B. The
                // previous pair stays on pair_out until B actually arrives.
                ST_GET_B: begin
                    if (nib_xfer) begin
                        b_q         <= nib_in;
                        pair_out_q  <= {a_q, nib_in};
                        wait_cnt_q  <= LATENCY;
                        nib_ready_q <= 1'b0;
                        state_q     <= ST_WAIT;
                    end
                end

                // The counter starts at the latency and counts down to zero.
                // res_in is sampled on the edge where the counter is already
                // zero. That is one cycle after the adder's output register
                // updates, so res_in is stable when it is sampled.
                ST_WAIT: begin
                    if (wait_cnt_q == 4'h0) begin
                        res_valid_q  <= 1'b1;
                        res_data_q   <= res_in[3:0];
                        res_carry_q  <= sum_d[4];
                        mismatch_q   <= mismatch_d;
                        pair_count_q <= pair_count_d;
                        err_count_q  <= err_count_d;
                        state_q      <= ST_REPORT;
                    end else begin
                        wait_cnt_q <= wait_cnt_q - 4'h1;
                    end
                end

                ST_REPORT: begin
                    res_valid_q <= 1'b0;
                    nib_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                    state_q     <= ST_GET_A;
                end

                default: begin
                    state_q     <= ST_GET_A;
                    nib_ready_q <= 1'b1;
                    res_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign nib_ready  = nib_ready_q;
    assign pair_out   = pair_out_q;
    assign res_valid  = res_valid_q;
    assign res_data   = res_data_q;
    assign res_carry  = res_carry_q;
    assign mismatch   = mismatch_q;
    assign pair_count = pair_count_q;
    assign err_count  = err_count_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_nibble_pair_sequencer.sv
// tb_nibble_pair_sequencer
//
// Scoreboard bench for nibble_pair_sequencer. A registered adder model sits
// on pair_out/res_in and can be forced to return a chosen byte. Stimulus
// pushes one expected record per pair. A monitor pops a record on every
// res_valid pulse and compares it. Two DUT instances share the stimulus: the
// main one (CNT_W=8) and a narrow one (CNT_W=2) for counter wrap/saturation.

module tb_nibble_pair_sequencer;

    localparam int LAT = 1;

    typedef struct {
        logic [7:0] pairOut;
        logic [3:0] resData;
        logic       resCarry;
        logic       mism;
        int         bCycle;
    } exp_t;

    logic       clk;
    logic       reset;
    logic [3:0] nibIn;
    logic       nibValid;
    logic [7:0] resIn;

    logic       nibReady,  nibReady2;
    logic [7:0] pairOut,   pairOut2;
    logic       resValid,  resValid2;
    logic [3:0] resData,   resData2;
    logic       resCarry,  resCarry2;
    logic       mism,      mism2;
    logic [7:0] pairCount, errCount;
    logic [1:0] pairCount2, errCount2;
    logic       busy,      busy2;

    logic       forceEn;
    logic [7:0] forceVal;

    exp_t expQ[$];
    int   checks;
    int   failures;
    int   cycle;
    int   modelPairs;
    int   modelErrs;
    int   pulses;

    nibble_pair_sequencer #(.RESULT_LATENCY(LAT), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .nib_in(nibIn), .nib_valid(nibValid),
        .nib_ready(nibReady), .pair_out(pairOut), .res_in(resIn),
        .res_valid(resValid), .res_data(resData), .res_carry(resCarry),
        .mismatch(mism), .pair_count(pairCount), .err_count(errCount),
        .busy(busy)
    );

    nibble_pair_sequencer #(.RESULT_LATENCY(LAT), .CNT_W(2)) dutNarrow (
        .clk(clk), .reset(reset), .nib_in(nibIn), .nib_valid(nibValid),
        .nib_ready(nibReady2), .pair_out(pairOut2), .res_in(resIn),
        .res_valid(resValid2), .res_data(resData2), .res_carry(resCarry2),
        .mismatch(mism2), .pair_count(pairCount2), .err_count(errCount2),
        .busy(busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Registered adder with one cycle of latency. It can be forced to return
    // an arbitrary byte so that mismatches can be provoked.
    always @(posedge clk) begin
        if (forceEn)
            resIn <= forceVal;
        else
            resIn <= ({4'h0, pairOut[7:4]} + {4'h0, pairOut[3:0]}) & 8'h0F;
    end

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic failEvent(input string name);
        checks++;
        failures++;
        $display("[TB] FAIL %s actual=event expected=none", name);
    endtask

    // Drives one nibble and returns once it has transferred. acceptCycle is
    // the cycle number after the accepting edge. nib_valid is left high.
    task automatic sendNibble(input logic [3:0] n, output int acceptCycle);
        int budget;
        budget   = 0;
        nibIn    = n;
        nibValid = 1'b1;
        while (!nibReady && budget < 64) begin
            @(negedge clk);
            budget++;
        end
        if (budget >= 64) failEvent("nib_ready_timeout");
        @(negedge clk);
        acceptCycle = cycle;
    endtask

    // Sends A then B with an optional gap in between. The adder can be
    // forced for this pair. The expected result is derived from A+B.
    task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b,
                                 input logic fEn, input logic [7:0] fVal,
                                 input int gap);
        int   c;
        int   sum;
        logic [7:0] seen;
        exp_t e;
        sendNibble(a, c);
        // Once A is accepted, the previous pair has already been reported,
        // so the force setting can change safely.
        forceEn  = fEn;
        forceVal = fVal;
        if (gap > 0) begin
            nibValid = 1'b0;
            nibIn    = 4'(~b);
            repeat (gap) @(negedge clk);
        end
        sendNibble(b, c);
        sum        = int'(a) + int'(b);
        seen       = fEn ? fVal : 8'(sum % 16);
        e.pairOut  = {a, b};
        e.resData  = seen[3:0];
        e.resCarry = (sum >= 16);
        e.mism     = (int'(seen) != sum % 16);
        e.bCycle   = c;
        expQ.push_back(e);
    endtask

    task automatic idleNib();
        nibValid = 1'b0;
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        idleNib();
        while (expQ.size() != 0 && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        checkOutput("scoreboard_drained", expQ.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic doReset();
        reset    = 1'b1;
        nibValid = 1'b0;
        forceEn  = 1'b0;
        expQ.delete();
        modelPairs = 0;
        modelErrs  = 0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic checkResetState();
        checkOutput("rst_nib_ready",  nibReady,  1);
        checkOutput("rst_pair_out",   pairOut,   0);
        checkOutput("rst_res_valid",  resValid,  0);
        checkOutput("rst_res_data",   resData,   0);
        checkOutput("rst_res_carry",  resCarry,  0);
        checkOutput("rst_mismatch",   mism,      0);
        checkOutput("rst_pair_count", pairCount, 0);
        checkOutput("rst_err_count",  errCount,  0);
        checkOutput("rst_busy",       busy,      0);
    endtask

    // Monitor: on every res_valid pulse, pop the oldest expected record and
    // compare every reported field. The counters are checked against a plain
    // count of pairs and errors since the last reset.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && resValid) begin
                pulses++;
                if (expQ.size() == 0) begin
                    failEvent("unexpected_res_valid");
                end else begin
                    e = expQ.pop_front();
                    modelPairs++;
                    if (e.mism) modelErrs++;
                    checkOutput("pair_out",   pairOut,  e.pairOut);
                    checkOutput("res_data",   resData,  e.resData);
                    checkOutput("res_carry",  resCarry, e.resCarry);
                    checkOutput("mismatch",   mism,     e.mism);
                    checkOutput("latency",    cycle - e.bCycle, LAT + 1);
                    checkOutput("nib_ready_in_report", nibReady, 0);
                    checkOutput("busy_in_report", busy, 1);
                    checkOutput("pair_count", pairCount, modelPairs % 256);
                    checkOutput("err_count",  errCount,
                                (modelErrs > 255) ? 255 : modelErrs);
                    checkOutput("narrow_res_valid",  resValid2, 1);
                    checkOutput("narrow_pair_count", pairCount2, modelPairs % 4);
                    checkOutput("narrow_err_count",  errCount2,
                                (modelErrs > 3) ? 3 : modelErrs);
                end
            end else if (!reset && resValid2) begin
                failEvent("narrow_unexpected_res_valid");
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog actual=running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int p0;
        int ign;
        checks     = 0;
        failures   = 0;
        cycle      = 0;
        pulses     = 0;
        modelPairs = 0;
        modelErrs  = 0;
        reset      = 1'b1;
        nibIn      = 4'h0;
        nibValid   = 1'b0;
        forceEn    = 1'b0;
        forceVal   = 8'h00;
        @(negedge clk);
        doReset();
        checkResetState();

        $display("[TB] basic pairs");
        applyStimulus(4'h3, 4'h5, 1'b0, 8'h00, 0);
        drain();
        applyStimulus(4'hF, 4'h2, 1'b0, 8'h00, 0);
        drain();

        $display("[TB] forced mismatches");
        applyStimulus(4'h3, 4'h5, 1'b1, 8'h07, 0);
        drain();
        applyStimulus(4'h3, 4'h5, 1'b1, 8'h18, 0);
        drain();
        forceEn = 1'b0;

        $display("[TB] continuous stream of 10 nibbles");
        p0 = pulses;
        for (int i = 0; i < 5; i++)
            applyStimulus(4'(i * 3 + 1), 4'(i * 5 + 7), 1'b0, 8'h00, 0);
        drain();
        checkOutput("stream_pulses", pulses - p0, 5);

        $display("[TB] reset during wait");
        sendNibble(4'h9, ign);
        sendNibble(4'h9, ign);
        doReset();
        checkResetState();
        applyStimulus(4'h1, 4'h1, 1'b0, 8'h00, 0);
        drain();
        checkOutput("post_reset_res_data", resData, 2);

        $display("[TB] narrow counter wrap and saturation");
        doReset();
        for (int i = 0; i < 5; i++)
            applyStimulus(4'(i), 4'(i + 2), 1'b1, 8'h80 | 8'(i), 0);
        drain();
        checkOutput("narrow_final_pair_count", pairCount2, 1);
        checkOutput("narrow_final_err_count",  errCount2,  3);

        $display("[TB] randomized pairs");
        doReset();
        for (int i = 0; i < 300; i++) begin
            logic [3:0] a;
            logic [3:0] b;
            logic       fe;
            a  = 4'($urandom_range(0, 15));
            b  = 4'($urandom_range(0, 15));
            fe = ($urandom_range(0, 3) == 0);
            applyStimulus(a, b, fe, 8'($urandom_range(0, 255)),
                          ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0);
            if ($urandom_range(0, 3) == 0) begin
                idleNib();
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
